// File: rtl/post_pkg.sv
// Shared definitions for the post-period countdown timer.
//   postState_e : FSM states (IDLE, RUN, DONE)
//   SEG_BLANK   : all segments off (active-low)
//   SEG_ROM     : active-low {dp,g,f,e,d,c,b,a} codes for digits 0..9
//   bcd_dec     : BCD decrement with borrow ripple (0 -> 9 per nibble)
//   bcd_sat     : clamps every nibble above 9 down to 9
//   to_bcd      : converts a small integer constant to packed BCD
// Helpers work on a fixed MAX_DIGITS-wide vector; callers zero-extend
// and truncate with width casts.
package post_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } postState_e;

    localparam int MAX_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Packed so that SEG_ROM[d] yields the code for digit d.
    localparam logic [9:0][7:0] SEG_ROM = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [31:0] bcd_dec(input logic [31:0] value);
        logic [31:0] result;
        logic        borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    result[4*i +: 4] = 4'd9;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end
        end
        return result;
    endfunction

    function automatic logic [31:0] bcd_sat(input logic [31:0] value);
        logic [31:0] result;
        result = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                result[4*i +: 4] = 4'd9;
            end
        end
        return result;
    endfunction

    function automatic logic [31:0] to_bcd(input int value);
        logic [31:0] result;
        int          rest;
        result = '0;
        rest   = (value < 0) ? 0 : value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            result[4*i +: 4] = 4'(rest % 10);
            rest             = rest / 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/post_period_timer_seg7_digit.sv
// One seven-segment digit decoder (purely combinational).
//   bcd   : BCD digit 0..9 (values above 9 show blank)
//   blank : forces all segments off
//   seg   : active-low {dp,g,f,e,d,c,b,a}; dp is always off
module seg7_digit
    import post_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (bcd <= 4'd9)) begin
            seg = SEG_ROM[bcd];
        end
    end

endmodule

// File: rtl/post_period_timer.sv
// Post-period countdown timer. A postSig rising edge loads a BCD duration
// which is then decremented once every TICK_DIV clocks; expiry pulses
// levelComplete for one cycle. Drives NUM_DIGITS seven-segment digits with
// leading-zero blanking and an optional blink over the last seconds.
//   Clk100M       : system clock
//   Rst_n         : asynchronous active-low reset
//   postSig       : start request (rising edge starts)
//   abort         : synchronous cancel, beats everything else
//   durBcd        : duration in BCD seconds, sampled on the start edge
//   busy          : high while counting
//   remBcd        : remaining seconds, BCD
//   levelComplete : one-cycle pulse at expiry
//   postSeg       : digit i at [8i+7:8i], active-low, registered (1-cycle lag)
module post_period_timer
    import post_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000000,
    parameter int BLINK_LAST = 3,
    parameter int RETRIGGER  = 0
) (
    input  logic                    Clk100M,
    input  logic                    Rst_n,
    input  logic                    postSig,
    input  logic                    abort,
    input  logic [NUM_DIGITS*4-1:0] durBcd,
    output logic                    busy,
    output logic [NUM_DIGITS*4-1:0] remBcd,
    output logic                    levelComplete,
    output logic [NUM_DIGITS*8-1:0] postSeg
);

    localparam int W  = NUM_DIGITS * 4;
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] BLINK_FROM = PW'(TICK_DIV / 2);
    localparam logic [W-1:0]  BLINK_BCD  = W'(to_bcd(BLINK_LAST));

    postState_e      stateReg, stateNext;
    logic [PW-1:0]   prescalerReg, prescalerNext;
    logic [W-1:0]    remBcdReg, remBcdNext;
    logic            postSigQReg;
    logic [W*2-1:0]  postSegReg;
    logic [W*2-1:0]  postSegNext;

    logic            startEdge;
    logic            tick;
    logic [W-1:0]    loadVal;
    logic [W-1:0]    decVal;
    logic            blinkOff;
    logic [NUM_DIGITS-1:0] digitBlank;

    assign startEdge = postSig & ~postSigQReg;
    assign tick      = (prescalerReg == TICK_LAST);
    assign loadVal   = W'(bcd_sat(32'(durBcd)));
    assign decVal    = W'(bcd_dec(32'(remBcdReg)));

    always_comb begin
        stateNext     = stateReg;
        prescalerNext = prescalerReg;
        remBcdNext    = remBcdReg;
        if (abort) begin
            stateNext     = IDLE;
            prescalerNext = '0;
            remBcdNext    = '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (startEdge) begin
                        remBcdNext    = loadVal;
                        prescalerNext = '0;
                        stateNext     = (loadVal == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // A reload also swallows an expiry landing in the same cycle.
                    if (startEdge && (RETRIGGER != 0)) begin
                        remBcdNext    = loadVal;
                        prescalerNext = '0;
                        stateNext     = (loadVal == '0) ? DONE : RUN;
                    end else if (tick) begin
                        prescalerNext = '0;
                        if (remBcdReg <= W'(1)) begin
                            remBcdNext = '0;
                            stateNext  = DONE;
                        end else begin
                            remBcdNext = decVal;
                        end
                    end else begin
                        prescalerNext = prescalerReg + PW'(1);
                    end
                end
                DONE: begin
                    remBcdNext = '0;
                    stateNext  = IDLE;
                end
                default: begin
                    remBcdNext    = '0;
                    prescalerNext = '0;
                    stateNext     = IDLE;
                end
            endcase
        end
    end

    // Blink blanks the whole display during the upper half of each second.
    assign blinkOff = (BLINK_LAST > 0) && (remBcdReg <= BLINK_BCD)
                      && (prescalerReg >= BLINK_FROM);

    // DONE needs no special case: remBcd is 0 there and no digit is blanked,
    // so every digit decodes to "0".
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic leadBlank;
        if (gi == 0) begin : g_first
            assign leadBlank = 1'b0;
        end else begin : g_upper
            assign leadBlank = ~|remBcdReg[W-1:4*gi];
        end

        assign digitBlank[gi] = (stateReg == IDLE)
                                || ((stateReg == RUN) && (blinkOff || leadBlank));

        seg7_digit u_seg (
            .bcd   (remBcdReg[4*gi +: 4]),
            .blank (digitBlank[gi]),
            .seg   (postSegNext[8*gi +: 8])
        );
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            stateReg     <= IDLE;
            prescalerReg <= '0;
            remBcdReg    <= '0;
            postSigQReg  <= 1'b0;
            postSegReg   <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            stateReg     <= stateNext;
            prescalerReg <= prescalerNext;
            remBcdReg    <= remBcdNext;
            postSigQReg  <= postSig;
            postSegReg   <= postSegNext;
        end
    end

    assign busy          = (stateReg == RUN);
    assign levelComplete = (stateReg == DONE);
    assign remBcd        = remBcdReg;
    assign postSeg       = postSegReg;

endmodule

// File: tb/tb_post_period_timer.sv
// Bench for post_period_timer. Two instances share the stimulus:
//   dutA : BLINK_LAST=3, RETRIGGER=1
//   dutB : BLINK_LAST=0, RETRIGGER=0
// A behavioural model tracks each instance as integer seconds plus a phase
// within the second; at every rising edge it pushes the expected outputs
// into a per-instance queue, and a monitor pops and compares on the
// falling edge.
module tb_post_period_timer;

    localparam int ND = 4;
    localparam int TD = 4;

    typedef struct packed {
        logic        busy;
        logic        lc;
        logic [15:0] rem;
        logic [31:0] seg;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        postSig;
    logic        abort;
    logic [15:0] durBcd;

    logic        busyA, lcA, busyB, lcB;
    logic [15:0] remA, remB;
    logic [31:0] segA, segB;

    int compared   = 0;
    int mismatched = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Model state per instance: mode 0=idle 1=counting 2=expired
    int mMode[2];
    int mRem[2];
    int mPhase[2];
    logic [31:0] mSeg[2];
    logic prevSig;
    int blinkLast[2] = '{3, 0};
    int retrig[2]    = '{1, 0};

    post_period_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLINK_LAST(3), .RETRIGGER(1)) dutA (
        .Clk100M(clk), .Rst_n(rstN), .postSig(postSig), .abort(abort), .durBcd(durBcd),
        .busy(busyA), .remBcd(remA), .levelComplete(lcA), .postSeg(segA)
    );

    post_period_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLINK_LAST(0), .RETRIGGER(0)) dutB (
        .Clk100M(clk), .Rst_n(rstN), .postSig(postSig), .abort(abort), .durBcd(durBcd),
        .busy(busyB), .remBcd(remB), .levelComplete(lcB), .postSeg(segB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] segCode(int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  default: return 8'h90;
        endcase
    endfunction

    function automatic logic [31:0] dispOf(int mode, int rem, int phase, int blink);
        logic [31:0] r;
        int p;
        r = 32'hFFFF_FFFF;
        if (mode == 2) return 32'hC0C0_C0C0;
        if (mode != 1) return r;
        if (blink > 0 && rem <= blink && phase >= TD / 2) return r;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            if (i == 0 || rem >= p) r[8*i +: 8] = segCode((rem / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int durVal(logic [15:0] b);
        int v, p, n;
        v = 0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            n = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            v = v + n * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] toBcd(int v);
        logic [15:0] r;
        int rest;
        rest = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(rest % 10);
            rest = rest / 10;
        end
        return r;
    endfunction

    // Reference model: advanced once per rising edge using the inputs the
    // DUTs sample on that edge.
    initial begin
        exp_t e;
        logic start;
        int   d;
        for (int k = 0; k < 2; k++) begin
            mMode[k] = 0; mRem[k] = 0; mPhase[k] = 0; mSeg[k] = 32'hFFFF_FFFF;
        end
        prevSig = 1'b0;
        forever begin
            @(posedge clk);
            start = postSig && !prevSig;
            d = durVal(durBcd);
            for (int k = 0; k < 2; k++) begin
                if (!rstN) begin
                    mMode[k] = 0; mRem[k] = 0; mPhase[k] = 0; mSeg[k] = 32'hFFFF_FFFF;
                end else begin
                    mSeg[k] = dispOf(mMode[k], mRem[k], mPhase[k], blinkLast[k]);
                    if (abort) begin
                        mMode[k] = 0; mRem[k] = 0; mPhase[k] = 0;
                    end else if (start && (mMode[k] == 0 || (mMode[k] == 1 && retrig[k] == 1))) begin
                        mRem[k] = d; mPhase[k] = 0;
                        mMode[k] = (d == 0) ? 2 : 1;
                    end else if (mMode[k] == 1) begin
                        if (mPhase[k] == TD - 1) begin
                            mPhase[k] = 0;
                            mRem[k] = mRem[k] - 1;
                            if (mRem[k] == 0) mMode[k] = 2;
                        end else begin
                            mPhase[k] = mPhase[k] + 1;
                        end
                    end else if (mMode[k] == 2) begin
                        mMode[k] = 0;
                    end
                end
                e.busy = (mMode[k] == 1);
                e.lc   = (mMode[k] == 2);
                e.rem  = toBcd(mRem[k]);
                e.seg  = mSeg[k];
                if (k == 0) q0.push_back(e); else q1.push_back(e);
            end
            prevSig = rstN ? postSig : 1'b0;
        end
    end

    task automatic check(string name, exp_t e, logic b, logic l, logic [15:0] r, logic [31:0] s);
        compared++;
        if ({b, l, r, s} !== {e.busy, e.lc, e.rem, e.seg}) begin
            mismatched++;
            $display("FAIL %s t=%0t got busy=%0b lc=%0b rem=%h seg=%h want busy=%0b lc=%0b rem=%h seg=%h",
                     name, $time, b, l, r, s, e.busy, e.lc, e.rem, e.seg);
        end
    endtask

    // Monitor: compares every cycle's outputs against the model's queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("dutA", e, busyA, lcA, remA, segA);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dutB", e, busyB, lcB, remB, segB);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic startPeriod(logic [15:0] d);
        durBcd  = d;
        postSig = 1'b1;
        $display("start period dur=%h at t=%0t", d, $time);
        cyc(1);
        postSig = 1'b0;
    endtask

    // Waits until instance A's model is counting with the given remaining
    // seconds and phase; an expired bound counts as a failed comparison.
    task automatic waitModel0(int rem, int phase, string name);
        int i;
        i = 0;
        while (!(mMode[0] == 1 && mRem[0] == rem && mPhase[0] == phase) && i < 400) begin
            cyc(1);
            i++;
        end
        compared++;
        if (i >= 400) begin
            mismatched++;
            $display("FAIL %s wait timed out got mode=%0d rem=%0d phase=%0d want rem=%0d phase=%0d",
                     name, mMode[0], mRem[0], mPhase[0], rem, phase);
        end
    endtask

    initial begin
        exp_t rstExp;
        logic [15:0] d;
        int n;
        rstExp = '{busy: 1'b0, lc: 1'b0, rem: 16'h0000, seg: 32'hFFFF_FFFF};
        rstN = 1'b0; postSig = 1'b0; abort = 1'b0; durBcd = '0;
        cyc(3);
        rstN = 1'b1;
        cyc(2);

        // Basic countdown from 12.
        startPeriod(16'h0012);
        cyc(55);

        // BCD borrow from 1000, then abort.
        startPeriod(16'h1000);
        cyc(8);
        abort = 1'b1; cyc(1); abort = 1'b0;
        cyc(2);

        // Zero duration with postSig held high afterwards.
        durBcd = 16'h0000;
        postSig = 1'b1;
        $display("start period dur=%h held high at t=%0t", durBcd, $time);
        cyc(10);
        postSig = 1'b0;
        cyc(2);

        // Abort coincident with the final tick.
        startPeriod(16'h0002);
        waitModel0(1, TD - 1, "abort_wait");
        abort = 1'b1; cyc(1); abort = 1'b0;
        cyc(3);

        // Start edge at remaining 3: A reloads 5, B ignores.
        startPeriod(16'h0007);
        waitModel0(3, 0, "retrig_wait");
        startPeriod(16'h0005);
        cyc(40);

        // Start edge coincident with the expiry tick.
        startPeriod(16'h0003);
        waitModel0(1, TD - 1, "retrig_expiry_wait");
        startPeriod(16'h0004);
        cyc(30);

        // Asynchronous reset in the middle of a count.
        startPeriod(16'h0007);
        cyc(3);
        #2 rstN = 1'b0;
        #1;
        check("async_rst_A", rstExp, busyA, lcA, remA, segA);
        check("async_rst_B", rstExp, busyB, lcB, remB, segB);
        cyc(2);
        rstN = 1'b1;
        cyc(2);

        // Randomised traffic, including saturating nibbles.
        for (int it = 0; it < 25; it++) begin
            d = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            startPeriod(d);
            n = $urandom_range(10, 130);
            repeat (n) begin
                postSig = ($urandom_range(0, 19) == 0);
                abort   = ($urandom_range(0, 79) == 0);
                durBcd  = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
                cyc(1);
            end
            postSig = 1'b0;
            abort   = 1'b0;
            cyc(2);
        end

        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
